mul_div_unit: RTL and testbench
===============================

Name: mul_div_unit

Overview:
Multi-cycle 16-bit multiply/divide unit placed directly downstream of the register file.
- Consumes the two read operands (A, B) and produces HI/LO results.
- Issues a one-cycle write-back (data, address, load) into the register file's C port.
- Iterative shift-add / restoring-divide datapath with a fixed latency, so the control FSM can stall deterministically.

Parameters:
WIDTH, 16, operand/result width (matches register width)
ADDR_W, 4, register address width (16 registers)

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  request; sampled only when busy=0
op  input  2  00 MULU, 01 MUL (signed), 10 DIVU, 11 DIV (signed); captured with start
a  input  WIDTH  operand A (multiplicand / dividend); captured with start
b  input  WIDTH  operand B (multiplier / divisor); captured with start
dst_addr  input  ADDR_W  write-back register; captured with start
busy  output  1  operation in progress
done  output  1  one-cycle completion pulse
div_zero  output  1  valid with done; divide by zero occurred
hi  output  WIDTH  product[31:16] / remainder; held until next done
lo  output  WIDTH  product[15:0] / quotient; held until next done
wr_en  output  1  register-file Load, one cycle
wr_addr  output  ADDR_W  register-file Caddr
wr_data  output  WIDTH  register-file C (= lo)

Behaviour:
- Reset: one clock; reset is asynchronous and active-low. While rst_n=0:
  - busy, done, div_zero, wr_en = 0.
  - hi, lo, wr_addr, wr_data = 0.
  - FSM goes to IDLE.
  - Reset mid-operation aborts the operation with no write-back and no done.
- FSM states:
  - IDLE: if start, capture op/a/b/dst_addr and go to CALC with count=0.
  - CALC: one iteration per cycle; go to FIX after 16 iterations.
  - FIX: apply sign correction; go to DONE.
  - DONE: one cycle; go to IDLE, or straight to CALC if start=1 in this cycle.
- Timing, with start sampled at edge E0:
  - busy=1 in cycles after E1..E17.
  - At E18, done=1, hi/lo updated, wr_en pulse, busy=0.
  - Latency is fixed at 18 edges for every op, including divide by zero.
- start while busy=1 is ignored. It is not queued and captured registers are unchanged.
- start during the DONE cycle is accepted; back-to-back throughput is one op per 18 cycles.
- Signed ops:
  - Take magnitudes in IDLE capture.
  - Run the unsigned core.
  - Negate in FIX: product if sign(a)^sign(b); quotient likewise; remainder takes the dividend's sign.
- Division truncates toward zero.
- MUL/MULU: hi:lo = full 32-bit product, no overflow.
- Divide by zero (b=0, DIVU or DIV): lo=0xFFFF, hi=a unchanged, div_zero=1 with done. div_zero=0 on all other completions.
- DIV 0x8000 / 0xFFFF: lo=0x8000, hi=0x0000, div_zero=0.
- Write-back:
  - wr_data = lo and wr_addr = captured dst_addr, both registered and valid with wr_en.
  - wr_en=0 when dst_addr=0 ($zero is never written); done still pulses.
- wr_en and done are never high for more than one consecutive cycle.

Decomposition:
- Shared package holds:
  - op encodings OP_MULU/OP_MUL/OP_DIVU/OP_DIV.
  - FSM state enum IDLE/CALC/FIX/DONE.
  - WIDTH/ADDR_W defaults and the ITER=16 constant.
- One natural sub-module: mdu_core, the unsigned iterative shift-add / restoring-divide datapath with the iteration counter.
- Top level keeps the FSM, sign handling, HI/LO and write-back registers.

Test Plan:
- MULU a=300, b=300, dst=5 -> at E18: hi=0x0001, lo=0x5F90, wr_en=1, wr_addr=5, wr_data=0x5F90; busy high E1..E17.
- MUL a=0xFFFE (-2), b=0x0003 -> hi=0xFFFF, lo=0xFFFA. DIVU 100/7 -> lo=0x000E, hi=0x0002.
- DIV a=0xFFF9 (-7), b=0x0002 -> lo=0xFFFD, hi=0xFFFF. DIV 0x8000/0xFFFF -> lo=0x8000, hi=0x0000.
- DIVU a=0x1234, b=0 -> at E18: lo=0xFFFF, hi=0x1234, div_zero=1. Then MULU 2*3 -> div_zero=0, lo=6.
- start re-asserted at E5 with different operands -> ignored, first result unchanged. start in DONE cycle -> second done at E36. dst_addr=0 -> done=1, wr_en=0.
- rst_n low at E9 mid-DIVU -> all outputs 0 immediately (asynchronous). After release: no done/wr_en, busy=0, and a new start completes normally.

Source files
------------

// File: rtl/mul_div_unit_pkg.sv
// Shared definitions for the multi-cycle multiply/divide unit:
// operation encodings, FSM states and sizing constants.
package mul_div_unit_pkg;

  localparam int WIDTH_DEF  = 16;
  localparam int ADDR_W_DEF = 4;
  localparam int ITER       = 16;

  typedef enum logic [1:0] {
    OP_MULU = 2'b00,
    OP_MUL  = 2'b01,
    OP_DIVU = 2'b10,
    OP_DIV  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX,
    DONE
  } state_e;

  function automatic logic op_is_div(input op_e op);
    return op[1];
  endfunction

  function automatic logic op_is_signed(input op_e op);
    return op[0];
  endfunction

endpackage

// File: rtl/mul_div_unit_core.sv
// Unsigned iterative datapath: one shift-add multiply or restoring-divide
// step per enabled cycle, with its own iteration counter.
module mdu_core
  import mul_div_unit_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             step,
  input  logic             is_div,
  input  logic [WIDTH-1:0] a_mag,
  input  logic [WIDTH-1:0] b_mag,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             last
);

  localparam int CNT_W = $clog2(ITER);

  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [WIDTH-1:0] opnd_q, opnd_d;
  logic             div_q, div_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [WIDTH:0] sum;
  logic [WIDTH:0] part;
  logic [WIDTH:0] rem_sh;
  logic [WIDTH:0] diff;

  assign sum    = {1'b0, hi_q} + {1'b0, opnd_q};
  assign part   = lo_q[0] ? sum : {1'b0, hi_q};
  assign rem_sh = {hi_q, lo_q[WIDTH-1]};
  assign diff   = rem_sh - {1'b0, opnd_q};

  // Multiply: hi:lo starts as 0:multiplier and shifts right each step.
  // Divide: hi is the partial remainder, lo shifts the dividend out and
  // the quotient bits in.
  always_comb begin
    // NOTE: every signal gets a default before any branch so no latch is inferred.
    hi_d   = hi_q;
    lo_d   = lo_q;
    opnd_d = opnd_q;
    div_d  = div_q;
    cnt_d  = cnt_q;
    if (load) begin
      hi_d   = '0;
      lo_d   = is_div ? a_mag : b_mag;
      opnd_d = is_div ? b_mag : a_mag;
      div_d  = is_div;
      cnt_d  = '0;
    end else if (step) begin
      cnt_d = cnt_q + 1'b1;
      if (div_q) begin
        if (!diff[WIDTH]) begin
          hi_d = diff[WIDTH-1:0];
          lo_d = {lo_q[WIDTH-2:0], 1'b1};
        end else begin
          hi_d = rem_sh[WIDTH-1:0];
          lo_d = {lo_q[WIDTH-2:0], 1'b0};
        end
      end else begin
        hi_d = part[WIDTH:1];
        lo_d = {part[0], lo_q[WIDTH-1:1]};
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi_q   <= '0;
      lo_q   <= '0;
      opnd_q <= '0;
      div_q  <= 1'b0;
      cnt_q  <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      hi_q   <= hi_d;
      lo_q   <= lo_d;
      opnd_q <= opnd_d;
      div_q  <= div_d;
      cnt_q  <= cnt_d;
    end
  end

  assign hi   = hi_q;
  assign lo   = lo_q;
  assign last = (cnt_q == CNT_W'(ITER - 1));

endmodule

// File: rtl/mul_div_unit.sv
// 16-bit multi-cycle multiply/divide unit with fixed 18-edge latency and a
// one-cycle register-file write-back of the low result.
module mul_div_unit
  import mul_div_unit_pkg::*;
#(
  parameter int WIDTH  = WIDTH_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [1:0]        op,
  input  logic [WIDTH-1:0]  a,
  input  logic [WIDTH-1:0]  b,
  input  logic [ADDR_W-1:0] dst_addr,
  output logic              busy,
  output logic              done,
  output logic              div_zero,
  output logic [WIDTH-1:0]  hi,
  output logic [WIDTH-1:0]  lo,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [WIDTH-1:0]  wr_data
);

  state_e            state_q, state_d;
  op_e               op_q, op_d;
  logic [WIDTH-1:0]  a_q, a_d;
  logic [ADDR_W-1:0] dst_q, dst_d;
  logic              neg_q, neg_d;
  logic              rem_neg_q, rem_neg_d;
  logic              dz_q, dz_d;
  logic [WIDTH-1:0]  fix_hi_q, fix_hi_d, fix_lo_q, fix_lo_d;
  logic              done_q, done_d, div_zero_q, div_zero_d, wr_en_q, wr_en_d;
  logic [WIDTH-1:0]  hi_q, hi_d, lo_q, lo_d, wr_data_q, wr_data_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;

  logic               accept, in_signed, in_div;
  logic [WIDTH-1:0]   a_mag, b_mag, core_hi, core_lo;
  logic               core_last;
  logic [2*WIDTH-1:0] prod, prod_neg;

  // A start is honoured when idle or in the final DONE cycle (back-to-back).
  assign accept    = start && (state_q == IDLE || state_q == DONE);
  assign in_signed = op_is_signed(op_e'(op));
  assign in_div    = op_is_div(op_e'(op));
  assign a_mag     = (in_signed && a[WIDTH-1]) ? -a : a;
  assign b_mag     = (in_signed && b[WIDTH-1]) ? -b : b;
  assign prod      = {core_hi, core_lo};
  assign prod_neg  = -prod;

  mdu_core #(.WIDTH(WIDTH)) u_core (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (accept),
    .step   (state_q == CALC),
    .is_div (in_div),
    .a_mag  (a_mag),
    .b_mag  (b_mag),
    .hi     (core_hi),
    .lo     (core_lo),
    .last   (core_last)
  );

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    a_d        = a_q;
    dst_d      = dst_q;
    neg_d      = neg_q;
    rem_neg_d  = rem_neg_q;
    dz_d       = dz_q;
    fix_hi_d   = fix_hi_q;
    fix_lo_d   = fix_lo_q;
    done_d     = 1'b0;
    div_zero_d = 1'b0;
    wr_en_d    = 1'b0;
    hi_d       = hi_q;
    lo_d       = lo_q;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    case (state_q)
      IDLE: if (start) state_d = CALC;
      CALC: if (core_last) state_d = FIX;
      FIX: begin
        state_d = DONE;
        // Divide by zero bypasses sign correction: quotient all ones, hi = raw A.
        if (dz_q) begin
          fix_hi_d = a_q;
          fix_lo_d = '1;
        end else if (op_is_div(op_q)) begin
          fix_lo_d = neg_q ? -core_lo : core_lo;
          fix_hi_d = rem_neg_q ? -core_hi : core_hi;
        end else begin
          {fix_hi_d, fix_lo_d} = neg_q ? prod_neg : prod;
        end
      end
      DONE: begin
        state_d    = start ? CALC : IDLE;
        done_d     = 1'b1;
        div_zero_d = dz_q;
        hi_d       = fix_hi_q;
        lo_d       = fix_lo_q;
        wr_en_d    = (dst_q != '0);
        wr_addr_d  = dst_q;
        wr_data_d  = fix_lo_q;
      end
      default: state_d = IDLE;
    endcase
    if (accept) begin
      op_d      = op_e'(op);
      a_d       = a;
      dst_d     = dst_addr;
      neg_d     = in_signed && (a[WIDTH-1] ^ b[WIDTH-1]);
      rem_neg_d = in_signed && a[WIDTH-1];
      dz_d      = in_div && (b == '0);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      op_q       <= OP_MULU;
      a_q        <= '0;
      dst_q      <= '0;
      neg_q      <= 1'b0;
      rem_neg_q  <= 1'b0;
      dz_q       <= 1'b0;
      fix_hi_q   <= '0;
      fix_lo_q   <= '0;
      done_q     <= 1'b0;
      div_zero_q <= 1'b0;
      wr_en_q    <= 1'b0;
      hi_q       <= '0;
      lo_q       <= '0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      a_q        <= a_d;
      dst_q      <= dst_d;
      neg_q      <= neg_d;
      rem_neg_q  <= rem_neg_d;
      dz_q       <= dz_d;
      fix_hi_q   <= fix_hi_d;
      fix_lo_q   <= fix_lo_d;
      done_q     <= done_d;
      div_zero_q <= div_zero_d;
      wr_en_q    <= wr_en_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
    end
  end

  assign busy     = (state_q != IDLE);
  assign done     = done_q;
  assign div_zero = div_zero_q;
  assign hi       = hi_q;
  assign lo       = lo_q;
  assign wr_en    = wr_en_q;
  assign wr_addr  = wr_addr_q;
  assign wr_data  = wr_data_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Self-checking bench for mul_div_unit: directed cases from the test plan
// followed by randomized operations checked against an arithmetic model.
module tb_mul_div_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [1:0]  op_i;
  logic [15:0] a_i, b_i;
  logic [3:0]  dst_i;
  logic        busy, done, div_zero, wr_en;
  logic [15:0] hi, lo, wr_data;
  logic [3:0]  wr_addr;

  int checks   = 0;
  int failures = 0;

  mul_div_unit dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .op       (op_i),
    .a        (a_i),
    .b        (b_i),
    .dst_addr (dst_i),
    .busy     (busy),
    .done     (done),
    .div_zero (div_zero),
    .hi       (hi),
    .lo       (lo),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: {div_zero, hi, lo} from plain integer arithmetic.
  function automatic logic [32:0] model(input logic [1:0] o, input logic [15:0] x, input logic [15:0] y);
    int sx, sy;
    longint p;
    logic [15:0] q, r;
    sx = $signed(x);
    sy = $signed(y);
    case (o)
      2'b00: begin p = longint'(x) * longint'(y); return {1'b0, p[31:0]}; end
      2'b01: begin p = longint'(sx) * longint'(sy); return {1'b0, p[31:0]}; end
      2'b10: begin
        if (y == 16'd0) return {1'b1, x, 16'hFFFF};
        q = x / y;
        r = x % y;
        return {1'b0, r, q};
      end
      default: begin
        if (y == 16'd0) return {1'b1, x, 16'hFFFF};
        q = 16'(sx / sy);
        r = 16'(sx % sy);
        return {1'b0, r, q};
      end
    endcase
  endfunction

  // Drive a request so it is sampled at the next rising edge (E0).
  task automatic start_op(input logic [1:0] o, input logic [15:0] x, input logic [15:0] y, input logic [3:0] d);
    @(negedge clk);
    start = 1'b1; op_i = o; a_i = x; b_i = y; dst_i = d;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_edges(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic result_check(input string tag, input logic [1:0] o, input logic [15:0] x,
                              input logic [15:0] y, input logic [3:0] d);
    logic [32:0] exp;
    exp = model(o, x, y);
    check({tag, ".done"}, done, 1);
    check({tag, ".hi"}, hi, exp[31:16]);
    check({tag, ".lo"}, lo, exp[15:0]);
    check({tag, ".div_zero"}, div_zero, exp[32]);
    check({tag, ".wr_en"}, wr_en, d != 4'd0);
    if (d != 4'd0) begin
      check({tag, ".wr_addr"}, wr_addr, d);
      check({tag, ".wr_data"}, wr_data, exp[15:0]);
    end
  endtask

  task automatic run_op(input string tag, input logic [1:0] o, input logic [15:0] x,
                        input logic [15:0] y, input logic [3:0] d);
    start_op(o, x, y, d);
    wait_edges(18);
    result_check(tag, o, x, y, d);
  endtask

  initial begin
    rst_n = 1'b1; start = 1'b0; op_i = 2'b00; a_i = '0; b_i = '0; dst_i = '0;
    #1 rst_n = 1'b0;
    #1;
    check("rst.busy", busy, 0);
    check("rst.done", done, 0);
    check("rst.hi_lo", {hi, lo}, 0);
    check("rst.wr", {wr_en, wr_addr, wr_data, div_zero}, 0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;

    // MULU 300*300: busy through E1..E17, result at E18.
    start_op(2'b00, 16'd300, 16'd300, 4'd5);
    for (int i = 1; i <= 17; i++) begin
      wait_edges(1);
      check($sformatf("mulu.busy_E%0d", i), busy, 1);
      check($sformatf("mulu.nodone_E%0d", i), done, 0);
    end
    wait_edges(1);
    check("mulu.busy_E18", busy, 0);
    check("mulu.const_hi", hi, 16'h0001);
    check("mulu.const_lo", lo, 16'h5F90);
    result_check("mulu", 2'b00, 16'd300, 16'd300, 4'd5);
    wait_edges(1);
    check("mulu.done_pulse", {done, wr_en}, 0);

    run_op("mul_neg", 2'b01, 16'hFFFE, 16'h0003, 4'd1);
    check("mul_neg.const", {hi, lo}, 32'hFFFF_FFFA);
    run_op("divu", 2'b10, 16'd100, 16'd7, 4'd2);
    check("divu.const", {hi, lo}, 32'h0002_000E);
    run_op("div_neg", 2'b11, 16'hFFF9, 16'h0002, 4'd3);
    check("div_neg.const", {hi, lo}, 32'hFFFF_FFFD);
    run_op("div_min", 2'b11, 16'h8000, 16'hFFFF, 4'd4);
    check("div_min.const", {hi, lo}, 32'h0000_8000);
    run_op("divu_zero", 2'b10, 16'h1234, 16'h0000, 4'd6);
    check("divu_zero.const", {div_zero, hi, lo}, 33'h1_1234_FFFF);
    run_op("mulu_after_dz", 2'b00, 16'd2, 16'd3, 4'd7);
    check("mulu_after_dz.const", {div_zero, lo}, 17'h0_0006);
    run_op("div_zero_signed", 2'b11, 16'hFFFB, 16'h0000, 4'd8);

    // start re-asserted at E5 with other operands is ignored.
    start_op(2'b00, 16'h1234, 16'h0010, 4'd3);
    wait_edges(4);
    @(negedge clk);
    start = 1'b1; op_i = 2'b10; a_i = 16'd5; b_i = 16'd0; dst_i = 4'd9;
    @(posedge clk);
    @(negedge clk) start = 1'b0;
    wait_edges(13);
    result_check("ignored_start", 2'b00, 16'h1234, 16'h0010, 4'd3);

    // Back-to-back: start held during the DONE cycle, second done at E36.
    start_op(2'b01, 16'h0123, 16'hFF00, 4'd10);
    wait_edges(17);
    @(negedge clk);
    start = 1'b1; op_i = 2'b11; a_i = 16'hD8F1; b_i = 16'h0013; dst_i = 4'd11;
    wait_edges(1);
    result_check("b2b_first", 2'b01, 16'h0123, 16'hFF00, 4'd10);
    @(negedge clk) start = 1'b0;
    wait_edges(1);
    check("b2b.done_pulse", {done, wr_en}, 0);
    wait_edges(16);
    check("b2b.nodone_E35", done, 0);
    wait_edges(1);
    result_check("b2b_second", 2'b11, 16'hD8F1, 16'h0013, 4'd11);

    run_op("dst_zero", 2'b00, 16'd7, 16'd9, 4'd0);

    // Asynchronous reset mid-divide.
    start_op(2'b10, 16'hBEEF, 16'd3, 4'd9);
    wait_edges(9);
    rst_n = 1'b0;
    #1;
    check("midrst.busy", busy, 0);
    check("midrst.hi_lo", {hi, lo}, 0);
    check("midrst.outs", {done, div_zero, wr_en, wr_addr, wr_data}, 0);
    wait_edges(2);
    @(negedge clk) rst_n = 1'b1;
    for (int i = 0; i < 25; i++) begin
      wait_edges(1);
      check($sformatf("midrst.quiet%0d", i), {done, wr_en, busy}, 0);
    end
    run_op("after_rst", 2'b01, 16'hFFFF, 16'hFFFF, 4'd2);

    // Randomized operations against the model.
    for (int i = 0; i < 24; i++) begin
      logic [1:0]  o;
      logic [15:0] x, y;
      logic [3:0]  d;
      o = 2'($urandom_range(0, 3));
      x = 16'($urandom);
      y = 16'($urandom);
      if (i % 6 == 0) y = 16'd0;
      if (i % 5 == 1) y = 16'($urandom_range(1, 9));
      if (i % 7 == 3) x = 16'h8000;
      d = 4'($urandom_range(0, 15));
      run_op($sformatf("rand%0d_op%0d", i, o), o, x, y, d);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
